// File: rtl/iv_sweep_sequencer_if.sv
// Bias DAC, drain-current ADC and sample-stream signals of the I-V sweep sequencer.
// master = sequencer side, slave = DAC/ADC/capture side.
interface iv_sweep_sequencer_if #(
    parameter int DAC_W = 12,
    parameter int ADC_W = 16
);
    logic [DAC_W-1:0] dac_vgs;
    logic [DAC_W-1:0] dac_vds;
    logic             dac_load;
    logic             adc_req;
    logic             adc_ack;
    logic [ADC_W-1:0] adc_data;
    logic             out_valid;
    logic             out_ready;
    logic [DAC_W-1:0] out_vgs;
    logic [DAC_W-1:0] out_vds;
    logic [ADC_W-1:0] out_id;
    logic             out_last;

    modport master (
        output dac_vgs, dac_vds, dac_load, adc_req, out_valid,
               out_vgs, out_vds, out_id, out_last,
        input  adc_ack, adc_data, out_ready
    );

    modport slave (
        input  dac_vgs, dac_vds, dac_load, adc_req, out_valid,
               out_vgs, out_vds, out_id, out_last,
        output adc_ack, adc_data, out_ready
    );
endinterface

// File: rtl/iv_sweep_sequencer.sv
// Nested Vgs/Vds bias sweep: load DACs, settle, request one Id conversion per point,
// and stream (Vgs, Vds, Id) triples out over valid/ready.
module iv_sweep_sequencer #(
    parameter int DAC_W  = 12,
    parameter int ADC_W  = 16,
    parameter int CNT_W  = 10,
    parameter int SET_W  = 16,
    parameter bit NEG_ID = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DAC_W-1:0] vgs_start_i,
    input  logic [DAC_W-1:0] vgs_step_i,
    input  logic [CNT_W-1:0] vgs_count_i,
    input  logic [DAC_W-1:0] vds_start_i,
    input  logic [DAC_W-1:0] vds_step_i,
    input  logic [CNT_W-1:0] vds_count_i,
    input  logic [SET_W-1:0] settle_cycles_i,
    output logic             busy_o,
    output logic             done_o,
    iv_sweep_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DAC_W-1:0] vgs_q, vgs_d, vds_q, vds_d;
    logic [DAC_W-1:0] vgs_step_q, vgs_step_d, vds_step_q, vds_step_d;
    logic [DAC_W-1:0] vds_start_q, vds_start_d;
    logic [CNT_W-1:0] vgs_cnt_q, vgs_cnt_d, vds_cnt_q, vds_cnt_d;
    logic [CNT_W-1:0] vgs_idx_q, vgs_idx_d, vds_idx_q, vds_idx_d;
    logic [SET_W-1:0] settle_cfg_q, settle_cfg_d, settle_q, settle_d;
    logic [DAC_W-1:0] dac_vgs_q, dac_vgs_d, dac_vds_q, dac_vds_d;
    logic             dac_load_q, dac_load_d;
    logic [DAC_W-1:0] out_vgs_q, out_vgs_d, out_vds_q, out_vds_d;
    logic [ADC_W-1:0] out_id_q, out_id_d;
    logic             out_last_q, out_last_d;
    logic             vgs_last, vds_last;

    assign vgs_last = (vgs_idx_q == vgs_cnt_q - CNT_W'(1));
    assign vds_last = (vds_idx_q == vds_cnt_q - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        vgs_d        = vgs_q;
        vds_d        = vds_q;
        vgs_step_d   = vgs_step_q;
        vds_step_d   = vds_step_q;
        vds_start_d  = vds_start_q;
        vgs_cnt_d    = vgs_cnt_q;
        vds_cnt_d    = vds_cnt_q;
        vgs_idx_d    = vgs_idx_q;
        vds_idx_d    = vds_idx_q;
        settle_cfg_d = settle_cfg_q;
        settle_d     = settle_q;
        dac_vgs_d    = dac_vgs_q;
        dac_vds_d    = dac_vds_q;
        dac_load_d   = 1'b0;
        out_vgs_d    = out_vgs_q;
        out_vds_d    = out_vds_q;
        out_id_d     = out_id_q;
        out_last_d   = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    vgs_step_d   = vgs_step_i;
                    vds_step_d   = vds_step_i;
                    vds_start_d  = vds_start_i;
                    vgs_cnt_d    = vgs_count_i;
                    vds_cnt_d    = vds_count_i;
                    settle_cfg_d = settle_cycles_i;
                    vgs_d        = vgs_start_i;
                    vds_d        = vds_start_i;
                    vgs_idx_d    = '0;
                    vds_idx_d    = '0;
                    state_d      = (vgs_count_i == '0 || vds_count_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                settle_d = settle_cfg_q;
                state_d  = (settle_cfg_q == '0) ? S_CONVERT : S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) state_d = S_CONVERT;
            end
            S_CONVERT: begin
                if (bus.adc_ack) begin
                    out_id_d   = NEG_ID ? ('0 - bus.adc_data) : bus.adc_data;
                    out_vgs_d  = vgs_q;
                    out_vds_d  = vds_q;
                    out_last_d = vgs_last && vds_last;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (!vds_last) begin
                        vds_idx_d = vds_idx_q + CNT_W'(1);
                        vds_d     = vds_q + vds_step_q;
                        state_d   = S_LOAD;
                    end else if (!vgs_last) begin
                        vds_idx_d = '0;
                        vgs_idx_d = vgs_idx_q + CNT_W'(1);
                        vds_d     = vds_start_q;
                        vgs_d     = vgs_q + vgs_step_q;
                        state_d   = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // DAC codes are registered on the edge entering LOAD so dac_load and codes coincide.
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            dac_load_d = 1'b1;
            dac_vgs_d  = vgs_d;
            dac_vds_d  = vds_d;
        end

        // Abort overrides everything: park the DACs at the safe zero bias.
        if (abort_i && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            dac_vgs_d  = '0;
            dac_vds_d  = '0;
            dac_load_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vgs_q        <= '0;
            vds_q        <= '0;
            vgs_step_q   <= '0;
            vds_step_q   <= '0;
            vds_start_q  <= '0;
            vgs_cnt_q    <= '0;
            vds_cnt_q    <= '0;
            vgs_idx_q    <= '0;
            vds_idx_q    <= '0;
            settle_cfg_q <= '0;
            settle_q     <= '0;
            dac_vgs_q    <= '0;
            dac_vds_q    <= '0;
            dac_load_q   <= 1'b0;
            out_vgs_q    <= '0;
            out_vds_q    <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vgs_q        <= vgs_d;
            vds_q        <= vds_d;
            vgs_step_q   <= vgs_step_d;
            vds_step_q   <= vds_step_d;
            vds_start_q  <= vds_start_d;
            vgs_cnt_q    <= vgs_cnt_d;
            vds_cnt_q    <= vds_cnt_d;
            vgs_idx_q    <= vgs_idx_d;
            vds_idx_q    <= vds_idx_d;
            settle_cfg_q <= settle_cfg_d;
            settle_q     <= settle_d;
            dac_vgs_q    <= dac_vgs_d;
            dac_vds_q    <= dac_vds_d;
            dac_load_q   <= dac_load_d;
            out_vgs_q    <= out_vgs_d;
            out_vds_q    <= out_vds_d;
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.dac_vgs   = dac_vgs_q;
    assign bus.dac_vds   = dac_vds_q;
    assign bus.dac_load  = dac_load_q;
    assign bus.adc_req   = (state_q == S_CONVERT);
    assign bus.out_valid = (state_q == S_EMIT);
    assign bus.out_vgs   = out_vgs_q;
    assign bus.out_vds   = out_vds_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_iv_sweep_sequencer.sv
// Self-checking bench for iv_sweep_sequencer: directed test-plan sweeps plus randomized
// sweeps, each checked cycle by cycle against an arithmetic model of the bias grid.
module tb_iv_sweep_sequencer;
    localparam int DAC_W = 12;
    localparam int ADC_W = 16;
    localparam int CNT_W = 10;
    localparam int SET_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic [DAC_W-1:0] vgs_start = '0, vgs_step = '0, vds_start = '0, vds_step = '0;
    logic [CNT_W-1:0] vgs_count = '0, vds_count = '0;
    logic [SET_W-1:0] settle_cycles = '0;
    logic busy, done;

    iv_sweep_sequencer_if #(.DAC_W(DAC_W), .ADC_W(ADC_W)) bus ();

    iv_sweep_sequencer #(
        .DAC_W(DAC_W), .ADC_W(ADC_W), .CNT_W(CNT_W), .SET_W(SET_W), .NEG_ID(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .vgs_start_i(vgs_start), .vgs_step_i(vgs_step), .vgs_count_i(vgs_count),
        .vds_start_i(vds_start), .vds_step_i(vds_step), .vds_count_i(vds_count),
        .settle_cycles_i(settle_cycles), .busy_o(busy), .done_o(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int g_loads, g_dones, g_hs;
    logic [DAC_W-1:0] got_vgs[$], got_vds[$];
    logic [ADC_W-1:0] got_id[$];
    logic             got_last[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Bias code of grid index i: start + i*step, wrapping modulo 2^DAC_W.
    function automatic logic [DAC_W-1:0] code(input logic [DAC_W-1:0] s, input logic [DAC_W-1:0] st, input int i);
        logic [31:0] v;
        v = 32'(s) + 32'(st) * 32'(i);
        return v[DAC_W-1:0];
    endfunction

    function automatic logic [ADC_W-1:0] neg(input logic [ADC_W-1:0] d);
        return ~d + ADC_W'(1);
    endfunction

    // ack_dly < 0 picks a random 0..3 cycle ADC latency per point; abort_pt > 0 aborts
    // during CONVERT of that 1-based point; stall_k >= 0 holds ready low 10 cycles on that sample.
    task automatic sweep(input logic [DAC_W-1:0] gs, input logic [DAC_W-1:0] gst, input int gn,
                         input logic [DAC_W-1:0] ds, input logic [DAC_W-1:0] dst, input int dn,
                         input int st, input int ack_dly, input int rdy_pct, input int abort_pt,
                         input int stall_k, input bit use_fix, input logic [ADC_W-1:0] fix_data);
        int n, k, loads, dones, t, last_load, load_t, ack_t, req_age, dly, abort_t, stall_left;
        bit prev_req, prev_ack, prev_valid, prev_rdy, aborted, finished, seen_done, rdy, ack_now;
        logic [DAC_W-1:0] pv_vgs, pv_vds;
        logic [ADC_W-1:0] pv_id, dat, exp_id;
        logic             pv_last;
        logic [ADC_W-1:0] id_q[$];
        n = gn * dn; k = 0; loads = 0; dones = 0; t = 0; last_load = -100; load_t = 0;
        ack_t = 0; req_age = 0; abort_t = 0; stall_left = 0;
        prev_req = 0; prev_ack = 0; prev_valid = 0; prev_rdy = 0;
        aborted = 0; finished = 0; seen_done = 0;
        pv_vgs = '0; pv_vds = '0; pv_id = '0; pv_last = 1'b0;
        dly = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        got_vgs.delete(); got_vds.delete(); got_id.delete(); got_last.delete();

        @(negedge clk);
        vgs_start = gs; vgs_step = gst; vgs_count = CNT_W'(gn);
        vds_start = ds; vds_step = dst; vds_count = CNT_W'(dn);
        settle_cycles = SET_W'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!finished) begin
            t++;
            if (aborted) begin
                if (t == abort_t + 1) begin
                    chk("abort_busy", 32'(busy), 0);
                    chk("abort_req", 32'(bus.adc_req), 0);
                    chk("abort_valid", 32'(bus.out_valid), 0);
                    chk("abort_load", 32'(bus.dac_load), 1);
                    chk("abort_dac_vgs", 32'(bus.dac_vgs), 0);
                    chk("abort_dac_vds", 32'(bus.dac_vds), 0);
                end else begin
                    chk("abort_single_load", 32'(bus.dac_load), 0);
                    chk("abort_idle", 32'(busy), 0);
                end
                chk("abort_no_done", 32'(done), 0);
                if (t >= abort_t + 4) finished = 1;
            end else if (seen_done) begin
                chk("idle_after_done", 32'(busy), 0);
                chk("done_one_cycle", 32'(done), 0);
                finished = 1;
            end else begin
                chk("busy", 32'(busy), 1);
                if (bus.dac_load) begin
                    chk("load_not_adjacent", 32'(t - last_load > 1), 1);
                    if (ack_dly == 0 && rdy_pct >= 100 && loads > 0)
                        chk("point_period", 32'(t - last_load), 32'(3 + st));
                    if (loads < n) begin
                        chk("dac_vgs", 32'(bus.dac_vgs), 32'(code(gs, gst, loads / dn)));
                        chk("dac_vds", 32'(bus.dac_vds), 32'(code(ds, dst, loads % dn)));
                    end else begin
                        chk("load_count", 32'(loads + 1), 32'(n));
                    end
                    loads++; last_load = t; load_t = t;
                end
                if (bus.adc_req && !prev_req) begin
                    chk("req_after_settle", 32'(t), 32'(load_t + 1 + st));
                    req_age = 0;
                    if (ack_dly < 0) dly = $urandom_range(0, 3);
                end
                if (prev_req && !prev_ack) chk("req_held", 32'(bus.adc_req), 1);
                if (prev_req && prev_ack) chk("req_drop", 32'(bus.adc_req), 0);
                if (bus.out_valid && !prev_valid) begin
                    exp_id = (id_q.size() > 0) ? neg(id_q[0]) : 'x;
                    chk("valid_latency", 32'(t), 32'(ack_t + 1));
                    chk("out_vgs", 32'(bus.out_vgs), 32'(code(gs, gst, k / dn)));
                    chk("out_vds", 32'(bus.out_vds), 32'(code(ds, dst, k % dn)));
                    chk("out_id", 32'(bus.out_id), 32'(exp_id));
                    chk("out_last", 32'(bus.out_last), 32'(k == n - 1));
                    got_vgs.push_back(bus.out_vgs); got_vds.push_back(bus.out_vds);
                    got_id.push_back(bus.out_id); got_last.push_back(bus.out_last);
                    if (k == stall_k) stall_left = 10;
                end
                if (prev_valid && !prev_rdy) begin
                    chk("stall_valid", 32'(bus.out_valid), 1);
                    chk("stall_vgs", 32'(bus.out_vgs), 32'(pv_vgs));
                    chk("stall_vds", 32'(bus.out_vds), 32'(pv_vds));
                    chk("stall_id", 32'(bus.out_id), 32'(pv_id));
                    chk("stall_last", 32'(bus.out_last), 32'(pv_last));
                    chk("stall_no_load", 32'(bus.dac_load), 0);
                end
                if (prev_valid && prev_rdy) chk("valid_drop", 32'(bus.out_valid), 0);
                if (done) begin
                    dones++;
                    chk("done_samples", 32'(k), 32'(n));
                    chk("done_loads", 32'(loads), 32'(n));
                    seen_done = 1;
                end
            end
            if (t > 4000 && !finished) begin
                tests++; fails++;
                $display("FAIL sweep_timeout: got no completion after %0d cycles, required done", t);
                finished = 1;
            end

            // Drive inputs for the next cycle.
            pv_vgs = bus.out_vgs; pv_vds = bus.out_vds; pv_id = bus.out_id; pv_last = bus.out_last;
            ack_now = 0; dat = ADC_W'($urandom);
            abort = 1'b0; start = 1'b0;
            if (finished || aborted) begin
                rdy = 0;
            end else if (abort_pt > 0 && bus.adc_req && loads == abort_pt) begin
                abort = 1'b1; ack_now = 1; aborted = 1; abort_t = t; rdy = 0;
            end else begin
                if (bus.adc_req) begin
                    if (req_age == dly) begin
                        ack_now = 1;
                        if (use_fix) dat = fix_data;
                        id_q.push_back(dat);
                        ack_t = t;
                    end
                    req_age++;
                end else if ($urandom_range(0, 9) == 0) begin
                    ack_now = 1;
                end
                rdy = (int'($urandom_range(1, 100)) <= rdy_pct);
                if (stall_left > 0) begin rdy = 0; stall_left--; end
                if (bus.out_valid && rdy) begin
                    k++;
                    if (id_q.size() > 0) void'(id_q.pop_front());
                end
                if (!done && !seen_done && $urandom_range(0, 24) == 0) begin
                    start = 1'b1;
                    vgs_start = DAC_W'($urandom); vds_start = DAC_W'($urandom);
                    vgs_count = CNT_W'($urandom_range(0, 5)); vds_count = CNT_W'($urandom_range(0, 5));
                end
            end
            bus.adc_ack = ack_now; bus.adc_data = dat; bus.out_ready = rdy;
            prev_req = bus.adc_req; prev_ack = ack_now; prev_valid = bus.out_valid; prev_rdy = rdy;
            @(negedge clk);
        end
        bus.adc_ack = 1'b0; bus.out_ready = 1'b0; abort = 1'b0; start = 1'b0;
        g_loads = loads; g_dones = dones; g_hs = k;
    endtask

    initial begin
        bus.adc_ack = 1'b0; bus.adc_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dac_vgs", 32'(bus.dac_vgs), 0);
        chk("rst_dac_vds", 32'(bus.dac_vds), 0);
        chk("rst_dac_load", 32'(bus.dac_load), 0);
        chk("rst_adc_req", 32'(bus.adc_req), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        // Reference sweep: 3 x 4 grid, settle 5, ADC answers 2 cycles after request.
        sweep(12'd100, 12'd50, 3, 12'd0, 12'd200, 4, 5, 2, 100, -1, -1, 1'b0, '0);
        chk("ref_samples", 32'(got_vgs.size()), 12);
        chk("ref_loads", 32'(g_loads), 12);
        chk("ref_dones", 32'(g_dones), 1);
        if (got_vgs.size() == 12) begin
            chk("ref_first_vgs", 32'(got_vgs[0]), 100);
            chk("ref_second_vds", 32'(got_vds[1]), 200);
            chk("ref_last_vgs", 32'(got_vgs[11]), 200);
            chk("ref_last_vds", 32'(got_vds[11]), 600);
            chk("ref_11th_not_last", 32'(got_last[10]), 0);
            chk("ref_12th_last", 32'(got_last[11]), 1);
        end

        // Zero settle with same-cycle ack: one point every 3 cycles.
        sweep(12'd7, 12'd3, 2, 12'd9, 12'd1, 3, 0, 0, 100, -1, -1, 1'b0, '0);
        chk("fast_samples", 32'(g_hs), 6);

        // Vds wraps past 4095; NEG_ID turns -500 into 500.
        sweep(12'd0, 12'd0, 1, 12'd4000, 12'd200, 2, 1, 1, 100, -1, -1, 1'b1, 16'hFE0C);
        if (got_vds.size() == 2) begin
            chk("wrap_vds", 32'(got_vds[1]), 104);
            chk("neg_id", 32'(got_id[0]), 500);
        end else chk("wrap_samples", 32'(got_vds.size()), 2);

        // Most-negative sample negates to itself.
        sweep(12'd1, 12'd1, 1, 12'd1, 12'd1, 1, 0, 0, 100, -1, -1, 1'b1, 16'h8000);
        if (got_id.size() == 1) chk("neg_min", 32'(got_id[0]), 32'h8000);
        else chk("neg_min_samples", 32'(got_id.size()), 1);

        // Sink stalls 10 cycles on the third sample.
        sweep(12'd300, 12'd5, 2, 12'd10, 12'd20, 2, 1, 1, 100, -1, 2, 1'b0, '0);
        chk("stall_samples", 32'(g_hs), 4);

        // Abort during CONVERT of point 5, then a full sweep.
        sweep(12'd100, 12'd50, 3, 12'd0, 12'd200, 4, 2, 3, 100, 5, -1, 1'b0, '0);
        chk("abort_handshakes", 32'(g_hs), 4);
        chk("abort_dones", 32'(g_dones), 0);
        sweep(12'd100, 12'd50, 3, 12'd0, 12'd200, 4, 1, -1, 100, -1, -1, 1'b0, '0);
        chk("post_abort_dones", 32'(g_dones), 1);

        // Empty grids complete without touching the DACs.
        sweep(12'd55, 12'd1, 0, 12'd66, 12'd1, 3, 2, 0, 100, -1, -1, 1'b0, '0);
        chk("zero_vgs_loads", 32'(g_loads), 0);
        chk("zero_vgs_done", 32'(g_dones), 1);
        sweep(12'd55, 12'd1, 2, 12'd66, 12'd1, 0, 2, 0, 100, -1, -1, 1'b0, '0);
        chk("zero_vds_loads", 32'(g_loads), 0);

        // Randomized sweeps: random grid, settle, ADC latency and back-pressure.
        for (int i = 0; i < 20; i++) begin
            sweep(DAC_W'($urandom), DAC_W'($urandom), int'($urandom_range(1, 4)),
                  DAC_W'($urandom), DAC_W'($urandom), int'($urandom_range(1, 4)),
                  int'($urandom_range(0, 3)), -1, 70, -1, -1, 1'b0, '0);
        end

        // Reset asserted mid-sweep clears the outputs without waiting for a clock.
        @(negedge clk);
        vgs_start = 12'd1234; vgs_step = 12'd1; vgs_count = 10'd2;
        vds_start = 12'd777; vds_step = 12'd1; vds_count = 10'd2; settle_cycles = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_req", 32'(bus.adc_req), 1);
        chk("pre_reset_dac", 32'(bus.dac_vgs), 1234);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_req", 32'(bus.adc_req), 0);
        chk("mid_rst_dac_vgs", 32'(bus.dac_vgs), 0);
        chk("mid_rst_dac_vds", 32'(bus.dac_vds), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
